// File: rtl/debug_controller.sv
// debug_controller: command sequencer for the DEBUGGER UART link.
// It pops one command byte from the rx FIFO and drives the CPU run, halt
// and step controls. It answers with ACK (0x06) or NAK (0x15), or it streams
// the debug register window to the tx FIFO.
// Optional build macro DBG_CHECKSUM_EN appends a mod-256 checksum byte to
// every dump.
//
// Handshake: rd and wr are single-cycle registered pulses. rd pops the
// show-ahead rx head. wr pushes w_data into the tx FIFO. A push is only
// decided in a cycle where tx_full=0. Commands are fully serialized: a new
// byte is only taken in IDLE.
// The FSM state is held in `state` so that checkers can bind to it.
module debug_controller #(
    parameter int DUMP_BYTES = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_data,
    output logic              cpu_run_en,
    output logic              cpu_step,
    output logic              busy
);
    localparam int               CNT_W    = $clog2(DUMP_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_BYTES - 1);

    localparam logic [7:0] CMD_RUN  = 8'h72;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

`ifdef DBG_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, DECODE, RESP, DUMP, DONE, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, DECODE, RESP, DUMP, DONE} state_t;
`endif

    state_t            state, state_n;
    logic [7:0]        cmd, cmd_n;
    logic [7:0]        resp, resp_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              rd_n, wr_n, step_n, run_n, busy_n;
    logic [7:0]        w_data_n;
    logic [ADDR_W-1:0] addr_n;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]        csum, csum_n;
`endif

    // State and all outputs are registered; reset abandons any dump in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd        <= 8'h00;
            resp       <= 8'h00;
            cnt        <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            w_data     <= 8'h00;
            dbg_addr   <= '0;
            cpu_run_en <= 1'b0;
            cpu_step   <= 1'b0;
            busy       <= 1'b0;
`ifdef DBG_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            state      <= state_n;
            cmd        <= cmd_n;
            resp       <= resp_n;
            cnt        <= cnt_n;
            rd         <= rd_n;
            wr         <= wr_n;
            w_data     <= w_data_n;
            dbg_addr   <= addr_n;
            cpu_run_en <= run_n;
            cpu_step   <= step_n;
            busy       <= busy_n;
`ifdef DBG_CHECKSUM_EN
            csum       <= csum_n;
`endif
        end
    end

    // Next-state and next-output decode; pulses default low, levels hold
    always_comb begin
        state_n  = state;
        cmd_n    = cmd;
        resp_n   = resp;
        cnt_n    = cnt;
        rd_n     = 1'b0;
        wr_n     = 1'b0;
        step_n   = 1'b0;
        w_data_n = w_data;
        addr_n   = dbg_addr;
        run_n    = cpu_run_en;
`ifdef DBG_CHECKSUM_EN
        csum_n   = csum;
`endif
        case (state)
            IDLE: begin
                if (!rx_empty) begin
                    cmd_n   = r_data;
                    rd_n    = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                state_n = RESP;
                case (cmd)
                    CMD_RUN: begin
                        run_n  = 1'b1;
                        resp_n = ACK;
                    end
                    CMD_HALT: begin
                        run_n  = 1'b0;
                        resp_n = ACK;
                    end
                    CMD_STEP: begin
                        // Stepping a free-running CPU is refused
                        if (!cpu_run_en) begin
                            step_n = 1'b1;
                            resp_n = ACK;
                        end else begin
                            resp_n = NAK;
                        end
                    end
                    CMD_DUMP: begin
                        addr_n  = '0;
                        cnt_n   = '0;
`ifdef DBG_CHECKSUM_EN
                        csum_n  = 8'h00;
`endif
                        state_n = DUMP;
                    end
                    default: resp_n = NAK;
                endcase
            end
            RESP: begin
                if (!tx_full) begin
                    w_data_n = resp;
                    wr_n     = 1'b1;
                    state_n  = DONE;
                end
            end
            DUMP: begin
                if (!tx_full) begin
                    w_data_n = dbg_data;
                    wr_n     = 1'b1;
                    cnt_n    = cnt + 1'b1;
`ifdef DBG_CHECKSUM_EN
                    csum_n   = csum + dbg_data;
`endif
                    if (cnt == LAST_CNT) begin
                        // Address parks on the last entry instead of wrapping
`ifdef DBG_CHECKSUM_EN
                        state_n = CSUM;
`else
                        state_n = DONE;
`endif
                    end else begin
                        addr_n = dbg_addr + 1'b1;
                    end
                end
            end
`ifdef DBG_CHECKSUM_EN
            CSUM: begin
                if (!tx_full) begin
                    w_data_n = csum;
                    wr_n     = 1'b1;
                    state_n  = DONE;
                end
            end
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller. An rx FIFO model feeds command bytes.
// A scoreboard holds the expected tx byte stream. The debug window is
// modelled as dbg_data = dbg_addr ^ 0xA5.
module tb_debug_controller;
    localparam int DUMP_BYTES = 32;
    localparam int ADDR_W     = 5;
`ifdef DBG_CHECKSUM_EN
    localparam int DUMP_LEN = DUMP_BYTES + 1;
`else
    localparam int DUMP_LEN = DUMP_BYTES;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_empty = 1'b1;
    logic [7:0]        r_data = 8'h00;
    logic              rd;
    logic              tx_full = 1'b0;
    logic [7:0]        w_data;
    logic              wr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [7:0]        dbg_data;
    logic              cpu_run_en;
    logic              cpu_step;
    logic              busy;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int rd_cnt = 0;
    int got_cnt = 0;
    int step_cnt = 0;
    int step_run = 0;
    int step_len = 0;
    logic tx_full_d = 1'b0;

    debug_controller #(.DUMP_BYTES(DUMP_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .r_data(r_data),
        .rd(rd), .tx_full(tx_full), .w_data(w_data), .wr(wr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .cpu_run_en(cpu_run_en),
        .cpu_step(cpu_step), .busy(busy)
    );

    assign dbg_data = {3'b000, dbg_addr} ^ 8'hA5;

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // rx FIFO model, tx scoreboard and pulse monitors, sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0] e;
        if (rd) begin
            rd_cnt++;
            if (rx_q.size() > 0) e = rx_q.pop_front();
        end
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
        check("rd_wr_excl", {31'd0, rd & wr}, 0);
        if (wr) begin
            got_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_byte", {24'd0, w_data}, {24'd0, e});
            end else begin
                check("tx_extra", {31'd0, wr}, 0);
            end
        end
        if (tx_full && tx_full_d) check("stall_wr", {31'd0, wr}, 0);
        tx_full_d = tx_full;
        if (cpu_step) begin
            step_cnt++;
            step_run++;
        end else if (step_run != 0) begin
            step_len = step_run;
            step_run = 0;
        end
    end

    // driver tasks
    task automatic push_cmd(input logic [7:0] b);
        @(posedge clk);
        #2 rx_q.push_back(b);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i >= 4 && exp_q.size() == 0 && rx_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 1);
    endtask

    task automatic wait_got(input int target, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (got_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 1);
    endtask

    task automatic stall5();
        #2 tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #2 tx_full = 1'b0;
    endtask

    task automatic load_dump();
        logic [7:0] b;
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < DUMP_BYTES; i++) begin
            b = 8'(i) ^ 8'hA5;
            exp_q.push_back(b);
            s = s + b;
        end
`ifdef DBG_CHECKSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    initial begin
        int base;
        int s0;
        // reset state
        repeat (2) @(negedge clk);
        check("rst_rd", {31'd0, rd}, 0);
        check("rst_wr", {31'd0, wr}, 0);
        check("rst_w_data", {24'd0, w_data}, 0);
        check("rst_dbg_addr", {27'd0, dbg_addr}, 0);
        check("rst_run_en", {31'd0, cpu_run_en}, 0);
        check("rst_step", {31'd0, cpu_step}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // idle with nothing to do
        repeat (100) @(negedge clk);
        check("idle_rd", rd_cnt, 0);
        check("idle_wr", got_cnt, 0);
        check("idle_step", step_cnt, 0);
        check("idle_run_en", {31'd0, cpu_run_en}, 0);

        // run then step back-to-back: step refused while running
        s0 = step_cnt;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h15);
        push_cmd(8'h72);
        push_cmd(8'h73);
        wait_idle("idle_rs");
        check("run_en_after_r", {31'd0, cpu_run_en}, 1);
        check("no_step_running", step_cnt, s0);
        check("rd_count_rs", rd_cnt, 2);

        // repeated run is idempotent
        exp_q.push_back(8'h06);
        push_cmd(8'h72);
        wait_idle("idle_rr");
        check("run_en_rr", {31'd0, cpu_run_en}, 1);

        // halt then step: exactly one single-cycle step pulse
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h06);
        push_cmd(8'h68);
        push_cmd(8'h73);
        wait_idle("idle_hs");
        check("run_en_after_h", {31'd0, cpu_run_en}, 0);
        check("step_count", step_cnt, s0 + 1);
        check("step_width", step_len, 1);

        // unknown command
        exp_q.push_back(8'h15);
        push_cmd(8'h41);
        wait_idle("idle_unk");
        check("run_en_unk", {31'd0, cpu_run_en}, 0);

        // plain dump
        base = got_cnt;
        load_dump();
        push_cmd(8'h64);
        wait_idle("idle_dump");
        check("dump_len", got_cnt - base, DUMP_LEN);

        // dump with two stalls
        base = got_cnt;
        load_dump();
        push_cmd(8'h64);
        wait_got(base + 10, "stall1_reach");
        stall5();
        wait_got(base + 31, "stall2_reach");
        stall5();
        wait_idle("idle_stall");
        check("stall_dump_len", got_cnt - base, DUMP_LEN);

        // reset in the middle of a dump
        base = got_cnt;
        load_dump();
        push_cmd(8'h64);
        wait_got(base + 15, "mid_reach");
        #2 rst_n = 1'b0;
        exp_q.delete();
        base = got_cnt;
        repeat (3) @(negedge clk);
        check("mid_rst_wr", {31'd0, wr}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_bytes_after_rst", got_cnt, base);
        exp_q.push_back(8'h06);
        push_cmd(8'h72);
        wait_idle("idle_post_rst");
        check("post_rst_len", got_cnt, base + 1);
        check("post_rst_run_en", {31'd0, cpu_run_en}, 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
